// File: rtl/shot_arb_pkg.sv
// Shared definitions for the shot arbiter: FSM state encoding and shot counter width.
package shot_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StFire = 2'b01,
    StCool = 2'b10,
    StDone = 2'b11
  } shot_state_e;

  localparam int unsigned CountWidth = 16;

endpackage

// File: rtl/shot_arbiter_if.sv
// Request/grant/fire bundle between requesters (master) and the shot arbiter (slave).
// shot_count exists only when SHOT_ARB_COUNT_EN is defined.
interface shot_arbiter_if #(
  parameter int unsigned N = 4
);
  import shot_arb_pkg::*;

  logic         enable;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         fire;
  logic [N-1:0] done;
  logic         busy;
`ifdef SHOT_ARB_COUNT_EN
  logic [CountWidth-1:0] shot_count;

  modport master (output enable, req, input grant, fire, done, busy, shot_count);
  modport slave (input enable, req, output grant, fire, done, busy, shot_count);
`else
  modport master (output enable, req, input grant, fire, done, busy);
  modport slave (input enable, req, output grant, fire, done, busy);
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i, wrapping at N.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [N-1:0]    pick_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned j;

  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    // Scan N positions starting one past the previous winner; last_i itself comes last.
    for (int unsigned i = 1; i <= N; i++) begin
      j = (int'(last_i) + i) % N;
      if (!valid_o && req_i[j]) begin
        valid_o   = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/shot_arbiter.sv
// Round-robin owner of a shared shot resource: fire pulse, cooldown, one-cycle done to winner.
// Optional 16-bit completed-shot counter enabled by SHOT_ARB_COUNT_EN.
module shot_arbiter
  import shot_arb_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned FIRE_CYCLES = 3,
  parameter int unsigned COOL_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  shot_arbiter_if.slave  bus
);

  localparam int unsigned IdxW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntMax = (FIRE_CYCLES > COOL_CYCLES) ? FIRE_CYCLES : COOL_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  shot_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    done_q, done_d;
  logic            fire_q, fire_d;
  logic            busy_q, busy_d;
  logic            shot_done;

  logic [N-1:0]    pick;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;

  rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i   (bus.req),
    .last_i  (last_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win_d     = win_q;
    grant_d   = grant_q;
    fire_d    = fire_q;
    done_d    = '0;
    busy_d    = busy_q;
    shot_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.enable && pick_valid) begin
          grant_d = pick;
          win_d   = pick_idx;
          fire_d  = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CntW'(FIRE_CYCLES - 1);
          state_d = StFire;
        end
      end
      StFire: begin
        if (cnt_q == '0) begin
          fire_d = 1'b0;
          if (COOL_CYCLES > 0) begin
            cnt_d   = CntW'(COOL_CYCLES - 1);
            state_d = StCool;
          end else begin
            done_d  = grant_q;
            state_d = StDone;
          end
        end else begin
          cnt_d = CntW'(cnt_q - 1'b1);
        end
      end
      StCool: begin
        if (cnt_q == '0) begin
          done_d  = grant_q;
          state_d = StDone;
        end else begin
          cnt_d = CntW'(cnt_q - 1'b1);
        end
      end
      StDone: begin
        grant_d   = '0;
        busy_d    = 1'b0;
        last_d    = win_q;
        shot_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= IdxW'(N - 1);
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      fire_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      fire_q  <= fire_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.fire  = fire_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

`ifdef SHOT_ARB_COUNT_EN
  logic [CountWidth-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (shot_done) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.shot_count = count_q;
`else
  logic unused_shot_done;
  assign unused_shot_done = shot_done;
`endif

endmodule

// File: tb/tb_shot_arbiter.sv
// Directed + randomized bench for shot_arbiter against a shot-timeline reference model.
module tb_shot_arbiter;

  localparam int N    = 4;
  localparam int FC   = 3;
  localparam int CC   = 2;
  localparam int SHOT = FC + CC + 1;  // last position of a shot (the done cycle)

  logic clk = 1'b0;
  logic reset;

  shot_arbiter_if #(.N(N)) bus ();

  shot_arbiter #(
    .N           (N),
    .FIRE_CYCLES (FC),
    .COOL_CYCLES (CC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: position within the current shot (0 = idle, 1..SHOT), owner, rr pointer.
  int pos;
  int owner;
  int last;
  int count;

  task automatic model_reset();
    pos   = 0;
    owner = 0;
    last  = N - 1;
    count = 0;
  endtask

  task automatic model_step(input logic en, input logic [N-1:0] r);
    bit found;
    found = 0;
    if (pos == 0) begin
      if (en && r != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (!found && r[(last + k) % N]) begin
            found = 1;
            owner = (last + k) % N;
          end
        end
        pos = 1;
      end
    end else if (pos == SHOT) begin
      pos   = 0;
      last  = owner;
      count = (count + 1) % 65536;
    end else begin
      pos++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = (pos > 0) ? N'(1 << owner) : '0;
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("fire", 32'(bus.fire), 32'(pos >= 1 && pos <= FC));
    chk("done", 32'(bus.done), (pos == SHOT) ? 32'(eg) : 32'd0);
    chk("busy", 32'(bus.busy), 32'(pos > 0));
`ifdef SHOT_ARB_COUNT_EN
    chk("shot_count", 32'(bus.shot_count), 32'(count));
`endif
  endtask

  // Called on a falling edge: apply inputs, advance the model through the next rising edge,
  // then compare at the following falling edge.
  task automatic tick(input logic en, input logic [N-1:0] r);
    bus.enable = en;
    bus.req    = r;
    if (reset) model_step(en, r);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int guard;
    reset      = 1'b0;
    bus.enable = 1'b1;
    bus.req    = '0;
    model_reset();
    @(negedge clk);

    // Held in reset with toggling requests
    for (int i = 0; i < 4; i++) tick(1'b1, N'($urandom));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, '0);

    // Single request, released after one cycle
    tick(1'b1, 4'b0100);
    for (int i = 0; i < 8; i++) tick(1'b1, '0);

    // All requesting: full rotation and wrap back to 0
    for (int i = 0; i < 31; i++) tick(1'b1, 4'b1111);
    for (int i = 0; i < 7; i++) tick(1'b1, '0);

    // Request dropped mid-fire
    for (int i = 0; i < 2; i++) tick(1'b1, 4'b0010);
    for (int i = 0; i < 9; i++) tick(1'b1, '0);

    // Enable low blocks grants; dropping it mid-shot does not abort
    for (int i = 0; i < 5; i++) tick(1'b0, 4'b1111);
    for (int i = 0; i < 2; i++) tick(1'b1, 4'b1111);
    for (int i = 0; i < 9; i++) tick(1'b0, 4'b1111);

    // Asynchronous reset during cooldown
    guard = 0;
    while (!(pos > FC && pos < SHOT) && guard < 20) begin
      tick(1'b1, 4'b1111);
      guard++;
    end
    chk("reach_cool", 32'(pos > FC && pos < SHOT), 32'd1);
    #1 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    reset = 1'b1;
    for (int i = 0; i < 40; i++) tick(1'b1, 4'b1111);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 3) != 0), N'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
